fetch_queue_nw: RTL and testbench
=================================

# fetch_queue_nw

Parametrised N-wide instruction fetch queue between the dual-port instruction memory and decode of the superscalar core, generalising the fixed 2-wide fetch path to WIDTH slots per cycle. Accepts up to WIDTH instructions per cycle from imem, buffers them in a circular queue of DEPTH entries, and presents up to WIDTH in-order instructions to decode. It owns the fetch PC and provides a single-cycle flush for branch/jump redirects.

## Interface
- WIDTH, 2, fetch/issue slots per cycle (1..4)
- DEPTH, 8, queue entries; power of two, ≥ 2*WIDTH
- ADDR_W, 12, instruction address width
- clock  in  1  master clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- flush  in  1  discard queue contents, redirect fetch
- flush_pc  in  ADDR_W  redirect target
- enq_valid  in  WIDTH  per-slot valid from imem
- enq_instr  in  32*WIDTH  slot i at bits [32i+31:32i]
- enq_ready  out  1  queue can take a full WIDTH group
- deq_valid  out  WIDTH  per-slot valid to decode, contiguous from slot 0
- deq_instr  out  32*WIDTH  head instructions, slot 0 = oldest
- deq_pc  out  ADDR_W*WIDTH  PC of each deq slot
- deq_take  in  $clog2(WIDTH+1)  number consumed by decode this cycle
- fetch_pc  out  ADDR_W  address for imem slot 0; slot i reads fetch_pc+i
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry holds {instr[31:0], pc[ADDR_W-1:0]}; head/tail pointers wrap modulo DEPTH.
- Enqueue count n_in = number of leading consecutive 1s in enq_valid starting at slot 0; bits after first 0 ignored. Accepted only when enq_ready=1; otherwise n_in treated as 0.
- Entry written for slot i gets pc = fetch_pc + i (mod 2^ADDR_W).
- enq_ready = (DEPTH − count ≥ WIDTH), computed from current count only (dequeue in same cycle not credited).
- fetch_pc += n_in each accepted cycle, wrapping mod 2^ADDR_W.
- deq_valid[i] = (i < count); deq_instr/deq_pc slot i = entry at head+i; invalid slots drive 0.
- n_out = min(deq_take, count); head += n_out.
- count_next = count + n_in − n_out; simultaneous enq and deq legal, including on a full queue or wrap-around.
- flush has priority over enqueue and dequeue: next cycle count=0, head=tail=0, fetch_pc=flush_pc, enq data that cycle discarded.
- Reset values: count=0, deq_valid=0, deq_instr=0, deq_pc=0, enq_ready=1, fetch_pc=0, head=tail=0, perf counter=0.

## Timing
- Enqueue→dequeue latency: 1 cycle (written at edge N, on deq outputs after edge N, consumable in cycle N+1).
- deq_* outputs combinational from storage and pointers; no input-to-output combinational path except none (deq_take affects only next state).
- enq_ready depends only on registered count; fetch_pc registered.
- Flush takes effect at the edge it is sampled; fetch_pc=flush_pc visible the following cycle, first refilled instruction dequeuable two cycles after flush.
- Reset asserted mid-operation clears state asynchronously; release is synchronised externally; first enqueue allowed on first edge after release.

## Configuration
- FETCH_QUEUE_PERF_EN: when defined, adds output stall_cycles [31:0], incrementing each cycle deq_valid[0]=0 and flush=0, saturating at 32'hFFFFFFFF, cleared by reset and not by flush. When undefined, port and counter absent; all other behaviour identical.

## Test plan
- Reset release, WIDTH=2, DEPTH=8: enq_valid=2'b11 for 4 cycles, deq_take=0 → count 2,4,6,8; enq_ready falls when count=8 and fifth group ignored; fetch_pc=8.
- Full queue, enq_valid=2'b11 with deq_take=2 each cycle → count stays at 6 steady state after first deq (enq_ready uses pre-deq count), order and deq_pc strictly increasing across wrap.
- enq_valid=2'b10 → n_in=0, nothing written, fetch_pc unchanged; enq_valid=2'b01 → one entry, fetch_pc+1.
- count=3, deq_take=2 then deq_take=2 → second cycle consumes 1, count=0, deq_valid=2'b00, deq_instr=0.
- Flush with flush_pc=12'h040 while enq_valid=2'b11 and deq_take=1 → next cycle count=0, fetch_pc=12'h040, no entry from flush cycle ever dequeued.
- Reset pulled low mid-stream with count=5 → outputs immediately at reset values; with FETCH_QUEUE_PERF_EN, stall_cycles=0 and counts empty cycles after release.

Source files
------------

// File: rtl/fetch_queue_nw.sv
// rtl/fetch_queue_nw.sv - WIDTH-wide instruction fetch queue with fetch PC ownership and single-cycle flush
// Optional feature macro: FETCH_QUEUE_PERF_EN adds the stall_cycles performance counter output.
module fetch_queue_nw #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            flush_pc,
  input  logic [WIDTH-1:0]             enq_valid,
  input  logic [32*WIDTH-1:0]          enq_instr,
  output logic                         enq_ready,
  output logic [WIDTH-1:0]             deq_valid,
  output logic [32*WIDTH-1:0]          deq_instr,
  output logic [ADDR_W*WIDTH-1:0]      deq_pc,
  input  logic [$clog2(WIDTH+1)-1:0]   deq_take,
  output logic [ADDR_W-1:0]            fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(WIDTH+1);
  localparam int PW = $clog2(DEPTH);

  // Largest occupancy that still leaves room for a whole WIDTH group.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - WIDTH);

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  logic [TW-1:0]     n_lead;
  logic              run;
  logic [TW-1:0]     n_in;
  logic [CW-1:0]     take_ext;
  logic [CW-1:0]     n_out;

  // Ready looks only at the registered count; same-cycle dequeues earn no credit.
  assign enq_ready = (count <= READY_MAX);

  // Count the leading run of valid slots starting at slot 0; anything after the first gap is dropped.
  always_comb begin
    n_lead = '0;
    run    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && enq_valid[i]) begin
        n_lead = n_lead + TW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Flush discards the incoming group, so an enqueue only counts when ready and not flushing.
  assign n_in = (enq_ready && !flush) ? n_lead : '0;

  // Decode may ask for more than is present; never consume beyond the occupancy.
  assign take_ext = CW'(deq_take);
  assign n_out    = (take_ext < count) ? take_ext : count;

  // Write accepted slots at the tail, tagging each with its fetch address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i < int'(n_in)) begin
          mem_instr[tail + PW'(i)] <= enq_instr[32*i +: 32];
          mem_pc[tail + PW'(i)]    <= fetch_pc + ADDR_W'(i);
        end
      end
    end
  end

  // Pointer, occupancy and fetch PC update; flush wins over both enqueue and dequeue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= flush_pc;
    end else begin
      head     <= head + PW'(n_out);
      tail     <= tail + PW'(n_in);
      count    <= count + CW'(n_in) - n_out;
      fetch_pc <= fetch_pc + ADDR_W'(n_in);
    end
  end

  // Present the oldest entries in order; slots beyond the occupancy read as zero.
  always_comb begin
    deq_valid = '0;
    deq_instr = '0;
    deq_pc    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < count) begin
        deq_valid[i]                 = 1'b1;
        deq_instr[32*i +: 32]        = mem_instr[head + PW'(i)];
        deq_pc[ADDR_W*i +: ADDR_W]   = mem_pc[head + PW'(i)];
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // Count cycles where decode has nothing to take, excluding flush cycles; saturates and survives flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!deq_valid[0] && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_nw.sv
// tb/tb_fetch_queue_nw.sv - directed self-checking bench for fetch_queue_nw (WIDTH=2, DEPTH=8)
module tb_fetch_queue_nw;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [11:0] flush_pc;
  logic [1:0]  enq_valid;
  logic [63:0] enq_instr;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_instr;
  logic [23:0] deq_pc;
  logic [1:0]  deq_take;
  logic [11:0] fetch_pc;
  logic [3:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_pass;
  int n_total;
  logic [11:0] pc_model;

  fetch_queue_nw #(.WIDTH(2), .DEPTH(8), .ADDR_W(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .enq_valid (enq_valid),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .deq_take  (deq_take),
    .fetch_pc  (fetch_pc),
    .count     (count)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [11:0] p);
    return {20'hC0DE0, p};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; flush_pc = '0;
    enq_valid = '0; enq_instr = '0; deq_take = '0;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (enq_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", enq_ready); else n_pass++;
    n_total++; if (fetch_pc !== 12'h000) $display("FAIL reset_fetch_pc: got %h expected 000", fetch_pc); else n_pass++;
    n_total++; if ({deq_valid, deq_instr, deq_pc} !== 90'd0) $display("FAIL reset_deq: got %b/%h/%h expected all zero", deq_valid, deq_instr, deq_pc); else n_pass++;
    reset = 1'b1;
    pc_model = 12'h000;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      enq_valid = 2'b11;
      enq_instr = {mk(pc_model + 12'd1), mk(pc_model)};
      step();
      pc_model = pc_model + 12'd2;
      n_total++; if (count !== 4'(2*(k+1))) $display("FAIL fill_count_%0d: got %0d expected %0d", k, count, 2*(k+1)); else n_pass++;
    end
    n_total++; if (enq_ready !== 1'b0) $display("FAIL fill_ready_low: got %b expected 0", enq_ready); else n_pass++;
    n_total++; if (fetch_pc !== 12'd8) $display("FAIL fill_fetch_pc: got %h expected 008", fetch_pc); else n_pass++;
    n_total++; if (deq_pc !== {12'd1, 12'd0}) $display("FAIL fill_head_pc: got %h expected 001000", deq_pc); else n_pass++;
    n_total++; if (deq_instr !== {mk(12'd1), mk(12'd0)}) $display("FAIL fill_head_instr: got %h expected %h", deq_instr, {mk(12'd1), mk(12'd0)}); else n_pass++;
    enq_instr = {mk(12'd9), mk(12'd8)};
    step();
    n_total++; if (count !== 4'd8) $display("FAIL fill_fifth_ignored: got %0d expected 8", count); else n_pass++;
    n_total++; if (fetch_pc !== 12'd8) $display("FAIL fill_fifth_pc: got %h expected 008", fetch_pc); else n_pass++;
  endtask

  task automatic test_full_stream();
    logic [11:0] e0;
    logic [11:0] e1;
    enq_valid = 2'b11;
    deq_take  = 2'd2;
    for (int k = 1; k <= 6; k++) begin
      enq_instr = {mk(pc_model + 12'd1), mk(pc_model)};
      step();
      if (k > 1) pc_model = pc_model + 12'd2;
      e0 = 12'(2*k);
      e1 = 12'(2*k + 1);
      n_total++; if (count !== 4'd6) $display("FAIL stream_count_%0d: got %0d expected 6", k, count); else n_pass++;
      n_total++; if (deq_pc !== {e1, e0}) $display("FAIL stream_pc_%0d: got %h expected %h", k, deq_pc, {e1, e0}); else n_pass++;
      n_total++; if (deq_instr !== {mk(e1), mk(e0)}) $display("FAIL stream_instr_%0d: got %h expected %h", k, deq_instr, {mk(e1), mk(e0)}); else n_pass++;
    end
    n_total++; if (fetch_pc !== 12'd18) $display("FAIL stream_fetch_pc: got %h expected 012", fetch_pc); else n_pass++;
    enq_valid = 2'b00;
    for (int j = 1; j <= 3; j++) begin
      step();
      n_total++; if (count !== 4'(6 - 2*j)) $display("FAIL drain_count_%0d: got %0d expected %0d", j, count, 6 - 2*j); else n_pass++;
    end
    deq_take = 2'd0;
  endtask

  task automatic test_partial_valid();
    enq_valid = 2'b10;
    enq_instr = {mk(12'hEEE), mk(12'hEEE)};
    step();
    n_total++; if (count !== 4'd0) $display("FAIL gap_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (fetch_pc !== 12'd18) $display("FAIL gap_fetch_pc: got %h expected 012", fetch_pc); else n_pass++;
    enq_valid = 2'b01;
    enq_instr = {mk(12'hEEE), mk(12'd18)};
    step();
    n_total++; if (count !== 4'd1) $display("FAIL single_count: got %0d expected 1", count); else n_pass++;
    n_total++; if (fetch_pc !== 12'd19) $display("FAIL single_fetch_pc: got %h expected 013", fetch_pc); else n_pass++;
    n_total++; if (deq_valid !== 2'b01) $display("FAIL single_valid: got %b expected 01", deq_valid); else n_pass++;
    n_total++; if (deq_instr[31:0] !== mk(12'd18) || deq_pc[11:0] !== 12'd18) $display("FAIL single_entry: got %h@%h expected %h@012", deq_instr[31:0], deq_pc[11:0], mk(12'd18)); else n_pass++;
  endtask

  task automatic test_underflow();
    enq_valid = 2'b11;
    enq_instr = {mk(12'd20), mk(12'd19)};
    step();
    n_total++; if (count !== 4'd3) $display("FAIL under_setup: got %0d expected 3", count); else n_pass++;
    enq_valid = 2'b00;
    deq_take  = 2'd2;
    step();
    n_total++; if (count !== 4'd1 || deq_pc[11:0] !== 12'd20) $display("FAIL under_first: got %0d@%h expected 1@014", count, deq_pc[11:0]); else n_pass++;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL under_count: got %0d expected 0", count); else n_pass++;
    n_total++; if ({deq_valid, deq_instr, deq_pc} !== 90'd0) $display("FAIL under_outputs: got %b/%h/%h expected all zero", deq_valid, deq_instr, deq_pc); else n_pass++;
    deq_take = 2'd0;
  endtask

  task automatic test_flush();
    enq_valid = 2'b11;
    enq_instr = {mk(12'd22), mk(12'd21)};
    step();
    n_total++; if (count !== 4'd2) $display("FAIL flush_setup: got %0d expected 2", count); else n_pass++;
    flush = 1'b1; flush_pc = 12'h040; deq_take = 2'd1;
    enq_instr = {mk(12'hBAD), mk(12'hBAD)};
    step();
    n_total++; if (count !== 4'd0) $display("FAIL flush_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (fetch_pc !== 12'h040) $display("FAIL flush_fetch_pc: got %h expected 040", fetch_pc); else n_pass++;
    flush = 1'b0; deq_take = 2'd0; enq_valid = 2'b00;
    step();
    n_total++; if (count !== 4'd0 || deq_valid !== 2'b00) $display("FAIL flush_no_leak: got %0d/%b expected 0/00", count, deq_valid); else n_pass++;
    enq_valid = 2'b11;
    enq_instr = {mk(12'h041), mk(12'h040)};
    step();
    n_total++; if (deq_pc !== {12'h041, 12'h040} || deq_instr[31:0] !== mk(12'h040)) $display("FAIL flush_refill: got %h/%h expected 041040/%h", deq_pc, deq_instr[31:0], mk(12'h040)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    enq_valid = 2'b11;
    enq_instr = {mk(12'h043), mk(12'h042)};
    step();
    enq_valid = 2'b01;
    enq_instr = {mk(12'hEEE), mk(12'h044)};
    step();
    enq_valid = 2'b00;
    n_total++; if (count !== 4'd5) $display("FAIL mid_setup: got %0d expected 5", count); else n_pass++;
    #3;
    reset = 1'b0;
    #1;
    n_total++; if (count !== 4'd0 || enq_ready !== 1'b1 || fetch_pc !== 12'h000) $display("FAIL mid_reset_state: got %0d/%b/%h expected 0/1/000", count, enq_ready, fetch_pc); else n_pass++;
    n_total++; if ({deq_valid, deq_instr, deq_pc} !== 90'd0) $display("FAIL mid_reset_deq: got %b/%h/%h expected all zero", deq_valid, deq_instr, deq_pc); else n_pass++;
`ifdef FETCH_QUEUE_PERF_EN
    n_total++; if (stall_cycles !== 32'd0) $display("FAIL mid_reset_stall: got %0d expected 0", stall_cycles); else n_pass++;
`endif
    #2;
    reset = 1'b1;
    enq_valid = 2'b11;
    enq_instr = {mk(12'h001), mk(12'h000)};
    step();
    n_total++; if (count !== 4'd2 || deq_pc !== {12'h001, 12'h000}) $display("FAIL post_reset_enq: got %0d/%h expected 2/001000", count, deq_pc); else n_pass++;
`ifdef FETCH_QUEUE_PERF_EN
    n_total++; if (stall_cycles !== 32'd1) $display("FAIL post_reset_stall1: got %0d expected 1", stall_cycles); else n_pass++;
`endif
    enq_valid = 2'b00;
    deq_take  = 2'd2;
    step();
    step();
    n_total++; if (count !== 4'd0) $display("FAIL post_reset_drain: got %0d expected 0", count); else n_pass++;
`ifdef FETCH_QUEUE_PERF_EN
    n_total++; if (stall_cycles !== 32'd2) $display("FAIL post_reset_stall2: got %0d expected 2", stall_cycles); else n_pass++;
`endif
    deq_take = 2'd0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fill();
    test_full_stream();
    test_partial_valid();
    test_underflow();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
